// File: rtl/pipe_mips32.sv
// ============================================================================
//  Module      : pipe_mips32
//  Description : Five-stage (IF/ID/EX/MEM/WB) pipelined MIPS32-subset core
//                with unified word-addressed memory, 32x32 register file,
//                EX-stage forwarding and EX-stage branch resolution.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_mips32 #(
  parameter int MEM_WORDS = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Architectural state (names are observed hierarchically)
  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  // IF/ID
  logic        if_id_valid;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_npc;

  // ID/EX (a bubble has every control flag cleared)
  logic [5:0]  id_ex_op;
  logic [31:0] id_ex_npc, id_ex_a, id_ex_b, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest;
  logic        id_ex_alu_wr, id_ex_load, id_ex_store;
  logic        id_ex_beqz, id_ex_bneqz, id_ex_hlt;

  // EX/MEM
  logic [31:0] ex_mem_alu, ex_mem_b;
  logic [4:0]  ex_mem_dest;
  logic        ex_mem_alu_wr, ex_mem_load, ex_mem_store, ex_mem_hlt;

  // MEM/WB
  logic [31:0] mem_wb_alu, mem_wb_lmd;
  logic [4:0]  mem_wb_dest;
  logic        mem_wb_alu_wr, mem_wb_load, mem_wb_hlt;

  // Decode results
  logic [5:0]  dec_op;
  logic [4:0]  dec_rs, dec_rt, dec_dest;
  logic [31:0] dec_imm, dec_a, dec_b;
  logic        dec_alu_wr, dec_load, dec_store, dec_beqz, dec_bneqz, dec_hlt;

  // Writeback, forwarding, execute
  logic        wb_we;
  logic [31:0] wb_data;
  logic [31:0] op_a, op_b, alu_out, br_target;
  logic        br_taken;
  logic        freeze;

  assign halted = HALTED;

  // A HLT in WB freezes everything younger at the same edge it sets HALTED
  assign freeze  = HALTED | mem_wb_hlt;
  assign wb_we   = (mem_wb_alu_wr | mem_wb_load) && (mem_wb_dest != 5'd0);
  assign wb_data = mem_wb_load ? mem_wb_lmd : mem_wb_alu;

  // Instruction decode and write-before-read register fetch
  always_comb begin
    dec_op     = if_id_ir[31:26];
    dec_rs     = if_id_ir[25:21];
    dec_rt     = if_id_ir[20:16];
    dec_imm    = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
    dec_alu_wr = 1'b0;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_beqz   = 1'b0;
    dec_bneqz  = 1'b0;
    dec_hlt    = 1'b0;
    dec_dest   = if_id_ir[20:16];
    case (dec_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        dec_alu_wr = if_id_valid;
        dec_dest   = if_id_ir[15:11];
      end
      OP_ADDI, OP_SUBI, OP_SLTI: dec_alu_wr = if_id_valid;
      OP_LW:    dec_load  = if_id_valid;
      OP_SW:    dec_store = if_id_valid;
      OP_BEQZ:  dec_beqz  = if_id_valid;
      OP_BNEQZ: dec_bneqz = if_id_valid;
      OP_HLT:   dec_hlt   = if_id_valid;
      default: ;
    endcase
    if (dec_rs == 5'd0)                        dec_a = 32'd0;
    else if (wb_we && (mem_wb_dest == dec_rs)) dec_a = wb_data;
    else                                       dec_a = Reg[dec_rs];
    if (dec_rt == 5'd0)                        dec_b = 32'd0;
    else if (wb_we && (mem_wb_dest == dec_rt)) dec_b = wb_data;
    else                                       dec_b = Reg[dec_rt];
  end

  // EX operand forwarding (younger EX/MEM wins), ALU and branch resolution
  always_comb begin
    if (ex_mem_alu_wr && (ex_mem_dest != 5'd0) && (ex_mem_dest == id_ex_rs))
      op_a = ex_mem_alu;
    else if (wb_we && (mem_wb_dest == id_ex_rs))
      op_a = wb_data;
    else
      op_a = id_ex_a;
    if (ex_mem_alu_wr && (ex_mem_dest != 5'd0) && (ex_mem_dest == id_ex_rt))
      op_b = ex_mem_alu;
    else if (wb_we && (mem_wb_dest == id_ex_rt))
      op_b = wb_data;
    else
      op_b = id_ex_b;
    case (id_ex_op)
      OP_ADD:       alu_out = op_a + op_b;
      OP_SUB:       alu_out = op_a - op_b;
      OP_AND:       alu_out = op_a & op_b;
      OP_OR:        alu_out = op_a | op_b;
      OP_SLT:       alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_MUL:       alu_out = op_a * op_b;
      OP_ADDI:      alu_out = op_a + id_ex_imm;
      OP_SUBI:      alu_out = op_a - id_ex_imm;
      OP_SLTI:      alu_out = {31'd0, $signed(op_a) < $signed(id_ex_imm)};
      OP_LW, OP_SW: alu_out = op_a + id_ex_imm;
      default:      alu_out = 32'd0;
    endcase
    br_taken  = (id_ex_beqz & (op_a == 32'd0)) | (id_ex_bneqz & (op_a != 32'd0));
    br_target = id_ex_npc + id_ex_imm;
  end

  // Pipeline advance, PC update, branch squash and halt freeze
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PC            <= 32'd0;
      HALTED        <= 1'b0;
      TAKEN_BRANCH  <= 1'b0;
      if_id_valid   <= 1'b0;
      if_id_ir      <= 32'd0;
      if_id_npc     <= 32'd0;
      id_ex_op      <= 6'd0;
      id_ex_npc     <= 32'd0;
      id_ex_a       <= 32'd0;
      id_ex_b       <= 32'd0;
      id_ex_imm     <= 32'd0;
      id_ex_rs      <= 5'd0;
      id_ex_rt      <= 5'd0;
      id_ex_dest    <= 5'd0;
      id_ex_alu_wr  <= 1'b0;
      id_ex_load    <= 1'b0;
      id_ex_store   <= 1'b0;
      id_ex_beqz    <= 1'b0;
      id_ex_bneqz   <= 1'b0;
      id_ex_hlt     <= 1'b0;
      ex_mem_alu    <= 32'd0;
      ex_mem_b      <= 32'd0;
      ex_mem_dest   <= 5'd0;
      ex_mem_alu_wr <= 1'b0;
      ex_mem_load   <= 1'b0;
      ex_mem_store  <= 1'b0;
      ex_mem_hlt    <= 1'b0;
      mem_wb_alu    <= 32'd0;
      mem_wb_lmd    <= 32'd0;
      mem_wb_dest   <= 5'd0;
      mem_wb_alu_wr <= 1'b0;
      mem_wb_load   <= 1'b0;
      mem_wb_hlt    <= 1'b0;
    end else if (freeze) begin
      HALTED       <= 1'b1;
      TAKEN_BRANCH <= 1'b0;
    end else begin
      TAKEN_BRANCH <= br_taken;
      // IF
      PC          <= br_taken ? br_target : PC + 32'd1;
      if_id_valid <= ~br_taken;
      if_id_ir    <= Mem[PC[AW-1:0]];
      if_id_npc   <= PC + 32'd1;
      // ID (squashed to a bubble behind a taken branch)
      id_ex_op     <= dec_op;
      id_ex_npc    <= if_id_npc;
      id_ex_a      <= dec_a;
      id_ex_b      <= dec_b;
      id_ex_imm    <= dec_imm;
      id_ex_rs     <= dec_rs;
      id_ex_rt     <= dec_rt;
      id_ex_dest   <= dec_dest;
      id_ex_alu_wr <= dec_alu_wr & ~br_taken;
      id_ex_load   <= dec_load   & ~br_taken;
      id_ex_store  <= dec_store  & ~br_taken;
      id_ex_beqz   <= dec_beqz   & ~br_taken;
      id_ex_bneqz  <= dec_bneqz  & ~br_taken;
      id_ex_hlt    <= dec_hlt    & ~br_taken;
      // EX
      ex_mem_alu    <= alu_out;
      ex_mem_b      <= op_b;
      ex_mem_dest   <= id_ex_dest;
      ex_mem_alu_wr <= id_ex_alu_wr;
      ex_mem_load   <= id_ex_load;
      ex_mem_store  <= id_ex_store;
      ex_mem_hlt    <= id_ex_hlt;
      // MEM
      mem_wb_alu    <= ex_mem_alu;
      mem_wb_lmd    <= Mem[ex_mem_alu[AW-1:0]];
      mem_wb_dest   <= ex_mem_dest;
      mem_wb_alu_wr <= ex_mem_alu_wr;
      mem_wb_load   <= ex_mem_load;
      mem_wb_hlt    <= ex_mem_hlt;
    end
  end

  // Store in MEM stage; dropped under reset or halt freeze
  always_ff @(posedge clk) begin
    if (rst_n && !freeze && ex_mem_store)
      Mem[ex_mem_alu[AW-1:0]] <= ex_mem_b;
  end

  // Register writeback; R0 is never written
  always_ff @(posedge clk) begin
    if (rst_n && wb_we)
      Reg[mem_wb_dest] <= wb_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_mips32.sv
// ============================================================================
//  Module      : tb_pipe_mips32
//  Description : Self-checking bench for pipe_mips32 with an expected-state
//                scoreboard drained once each program halts.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_mips32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  int checks = 0;
  int failures = 0;
  int taken_pulses = 0;

  typedef struct {
    bit          is_mem;
    int          idx;
    logic [31:0] value;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];

  pipe_mips32 #(.MEM_WORDS(1024)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input int imm);
    logic [15:0] v;
    v = imm[15:0];
    return {op, rs, rt, v};
  endfunction

  function automatic logic [31:0] state_of(input bit is_mem, input int idx);
    return is_mem ? dut.Mem[idx] : dut.Reg[idx];
  endfunction

  task automatic expect_state(input bit is_mem, input int idx, input logic [31:0] v,
                              input string name);
    exp_t e;
    e.is_mem = is_mem; e.idx = idx; e.value = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic load_program();
    for (int i = 0; i < prog.size(); i++) dut.Mem[i] = prog[i];
  endtask

  task automatic apply_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic run_until_halt(input int max_cycles, input string name);
    int n;
    n = 0;
    taken_pulses = 0;
    while (halted !== 1'b1 && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
      if (dut.TAKEN_BRANCH === 1'b1) taken_pulses++;
    end
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL %s_halt: halted=%b required 1 within %0d cycles", name, halted, max_cycles);
    end
  endtask

  task automatic load_factorial();
    prog.delete();
    prog.push_back(32'h280a00c8); prog.push_back(32'h28020001);
    prog.push_back(32'h0e94a000); prog.push_back(32'h21430000);
    prog.push_back(32'h0e94a000); prog.push_back(32'h14431000);
    prog.push_back(32'h2c630001); prog.push_back(32'h0e94a000);
    prog.push_back(32'h3460fffc); prog.push_back(32'h2542fffe);
    prog.push_back(32'hfc000000);
    load_program();
  endtask

  task automatic test_reset();
    exp_t e;
    prog.delete();
    prog.push_back(enc_i(6'b001010, 5'd0, 5'd21, 4));
    prog.push_back(32'hfc000000);
    load_program();
    dut.Reg[5] = 32'd123;
    apply_reset();
    run_until_halt(50, "reset_pre");
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dut.PC !== 32'd0) begin failures++; $display("FAIL reset_pc: got %0d required 0", dut.PC); end
    checks++;
    if (dut.HALTED !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b required 0", dut.HALTED); end
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL reset_port: got %b required 0", halted); end
    checks++;
    if (dut.TAKEN_BRANCH !== 1'b0) begin failures++; $display("FAIL reset_taken: got %b required 0", dut.TAKEN_BRANCH); end
    @(negedge clk); rst_n = 1'b1;
    expect_state(1'b0, 5, 32'd123, "reset_keeps_r5");
    expect_state(1'b0, 21, 32'd4, "reset_prog_r21");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (state_of(e.is_mem, e.idx) !== e.value) begin
        failures++;
        $display("FAIL %s: got %0h required %0h", e.name, state_of(e.is_mem, e.idx), e.value);
      end
    end
  endtask

  task automatic test_factorial();
    exp_t e;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
    dut.Mem[200] = 32'd8;
    dut.Mem[198] = 32'd0;
    load_factorial();
    expect_state(1'b1, 198, 32'd40320, "fact_mem198");
    expect_state(1'b1, 200, 32'd8, "fact_mem200");
    expect_state(1'b0, 3, 32'd0, "fact_r3");
    expect_state(1'b0, 2, 32'd40320, "fact_r2");
    expect_state(1'b0, 10, 32'd200, "fact_r10");
    apply_reset();
    run_until_halt(400, "fact");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (state_of(e.is_mem, e.idx) !== e.value) begin
        failures++;
        $display("FAIL %s: got %0h required %0h", e.name, state_of(e.is_mem, e.idx), e.value);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 1; k < 20; k++) dut.Reg[k] = 32'hDEAD0000 + k;
    dut.Mem[60] = 32'd0;
    prog.delete();
    prog.push_back(enc_i(6'b001010, 5'd0, 5'd1, 5));        // ADDI R1,R0,5
    prog.push_back(enc_r(6'b000000, 5'd1, 5'd1, 5'd2));     // ADD  R2,R1,R1
    prog.push_back(enc_r(6'b000000, 5'd2, 5'd1, 5'd3));     // ADD  R3,R2,R1
    prog.push_back(enc_i(6'b001001, 5'd0, 5'd3, 60));       // SW   R3,60(R0)
    prog.push_back(enc_r(6'b000001, 5'd3, 5'd1, 5'd4));     // SUB  R4,R3,R1
    prog.push_back(enc_r(6'b000100, 5'd4, 5'd3, 5'd5));     // SLT  R5,R4,R3
    prog.push_back(enc_i(6'b001010, 5'd0, 5'd10, -3));      // ADDI R10,R0,-3
    prog.push_back(enc_r(6'b000100, 5'd10, 5'd1, 5'd11));   // SLT  R11,R10,R1
    prog.push_back(enc_i(6'b001100, 5'd1, 5'd6, -1));       // SLTI R6,R1,-1
    prog.push_back(enc_r(6'b000010, 5'd10, 5'd2, 5'd17));   // AND  R17,R10,R2
    prog.push_back(enc_r(6'b000011, 5'd10, 5'd2, 5'd18));   // OR   R18,R10,R2
    prog.push_back(enc_i(6'b001011, 5'd1, 5'd19, 7));       // SUBI R19,R1,7
    prog.push_back(32'hfc000000);
    load_program();
    expect_state(1'b0, 2, 32'd10, "b2b_r2");
    expect_state(1'b0, 3, 32'd15, "b2b_r3");
    expect_state(1'b1, 60, 32'd15, "b2b_sw_fwd");
    expect_state(1'b0, 4, 32'd10, "b2b_sub");
    expect_state(1'b0, 5, 32'd1, "b2b_slt");
    expect_state(1'b0, 11, 32'd1, "b2b_slt_signed");
    expect_state(1'b0, 6, 32'd0, "b2b_slti");
    expect_state(1'b0, 17, 32'd8, "b2b_and");
    expect_state(1'b0, 18, 32'hFFFFFFFF, "b2b_or");
    expect_state(1'b0, 19, 32'hFFFFFFFE, "b2b_subi");
    apply_reset();
    run_until_halt(100, "b2b");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (state_of(e.is_mem, e.idx) !== e.value) begin
        failures++;
        $display("FAIL %s: got %0h required %0h", e.name, state_of(e.is_mem, e.idx), e.value);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    dut.Reg[5] = 32'd11; dut.Reg[6] = 32'd22;
    dut.Reg[12] = 32'd0; dut.Reg[13] = 32'd0;
    prog.delete();
    prog.push_back(enc_i(6'b001101, 5'd0, 5'd0, 5));        // BNEQZ R0,+5 (not taken)
    prog.push_back(enc_i(6'b001010, 5'd0, 5'd13, 8));       // ADDI R13,R0,8
    prog.push_back(enc_i(6'b001110, 5'd0, 5'd0, 2));        // BEQZ R0,+2 -> 5
    prog.push_back(enc_i(6'b001010, 5'd0, 5'd5, 55));       // squashed
    prog.push_back(enc_i(6'b001010, 5'd0, 5'd6, 66));       // squashed
    prog.push_back(enc_i(6'b001010, 5'd0, 5'd12, 7));       // ADDI R12,R0,7
    prog.push_back(32'hfc000000);
    load_program();
    expect_state(1'b0, 5, 32'd11, "br_r5_kept");
    expect_state(1'b0, 6, 32'd22, "br_r6_kept");
    expect_state(1'b0, 12, 32'd7, "br_target_ran");
    expect_state(1'b0, 13, 32'd8, "br_fallthrough_ran");
    apply_reset();
    run_until_halt(100, "br");
    checks++;
    if (taken_pulses !== 1) begin
      failures++;
      $display("FAIL br_taken_pulses: got %0d required 1", taken_pulses);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (state_of(e.is_mem, e.idx) !== e.value) begin
        failures++;
        $display("FAIL %s: got %0h required %0h", e.name, state_of(e.is_mem, e.idx), e.value);
      end
    end
  endtask

  task automatic test_load_mul();
    exp_t e;
    dut.Mem[50] = 32'd7; dut.Mem[51] = 32'd100;
    dut.Reg[0] = 32'd0; dut.Reg[4] = 32'd0; dut.Reg[7] = 32'd0;
    dut.Reg[8] = 32'd99; dut.Reg[14] = 32'd3;
    dut.Reg[15] = 32'd0; dut.Reg[16] = 32'd0;
    prog.delete();
    prog.push_back(enc_i(6'b001000, 5'd0, 5'd4, 50));       // LW   R4,50(R0)
    prog.push_back(enc_i(6'b001010, 5'd0, 5'd0, 9));        // ADDI R0,R0,9
    prog.push_back(enc_r(6'b000101, 5'd4, 5'd4, 5'd7));     // MUL  R7,R4,R4
    prog.push_back(enc_r(6'b000000, 5'd0, 5'd0, 5'd8));     // ADD  R8,R0,R0
    prog.push_back(enc_i(6'b001000, 5'd0, 5'd14, 51));      // LW   R14,51(R0)
    prog.push_back(enc_r(6'b000000, 5'd14, 5'd0, 5'd15));   // ADD  R15,R14,R0 (load-use d=1)
    prog.push_back(enc_r(6'b000000, 5'd14, 5'd0, 5'd16));   // ADD  R16,R14,R0 (d=2)
    prog.push_back(32'hfc000000);
    load_program();
    expect_state(1'b0, 7, 32'd49, "lw_mul_r7");
    expect_state(1'b0, 0, 32'd0, "r0_zero");
    expect_state(1'b0, 8, 32'd0, "r0_reads_zero");
    expect_state(1'b0, 15, 32'd3, "load_use_d1");
    expect_state(1'b0, 16, 32'd100, "load_use_d2");
    apply_reset();
    run_until_halt(100, "lw");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (state_of(e.is_mem, e.idx) !== e.value) begin
        failures++;
        $display("FAIL %s: got %0h required %0h", e.name, state_of(e.is_mem, e.idx), e.value);
      end
    end
  endtask

  task automatic test_store_halt();
    exp_t e;
    dut.Reg[1] = 32'd77; dut.Reg[9] = 32'd3;
    dut.Mem[100] = 32'd0; dut.Mem[101] = 32'd0;
    prog.delete();
    prog.push_back(enc_i(6'b001001, 5'd0, 5'd1, 100));      // SW   R1,100(R0)
    prog.push_back(32'hfc000000);                           // HLT
    prog.push_back(enc_i(6'b001001, 5'd0, 5'd1, 101));      // SW   R1,101(R0) (never)
    prog.push_back(enc_i(6'b001010, 5'd0, 5'd9, 5));        // ADDI R9,R0,5   (never)
    load_program();
    expect_state(1'b1, 100, 32'd77, "sw_lands");
    expect_state(1'b1, 101, 32'd0, "sw_after_hlt_dropped");
    expect_state(1'b0, 9, 32'd3, "r9_unchanged");
    apply_reset();
    run_until_halt(100, "hlt");
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (dut.PC !== 32'd5) begin failures++; $display("FAIL hlt_pc_frozen: got %0d required 5", dut.PC); end
    checks++;
    if (halted !== 1'b1) begin failures++; $display("FAIL hlt_sticky: got %b required 1", halted); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (state_of(e.is_mem, e.idx) !== e.value) begin
        failures++;
        $display("FAIL %s: got %0h required %0h", e.name, state_of(e.is_mem, e.idx), e.value);
      end
    end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL hlt_cleared_by_reset: got %b required 0", halted); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_midrun_reset();
    exp_t e;
    dut.Mem[198] = 32'd0;
    dut.Mem[200] = 32'd8;
    load_factorial();
    apply_reset();
    repeat (25) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dut.PC !== 32'd0) begin failures++; $display("FAIL midrst_pc: got %0d required 0", dut.PC); end
    checks++;
    if (dut.HALTED !== 1'b0) begin failures++; $display("FAIL midrst_halted: got %b required 0", dut.HALTED); end
    @(negedge clk); rst_n = 1'b1;
    expect_state(1'b1, 198, 32'd40320, "midrst_mem198");
    expect_state(1'b1, 200, 32'd8, "midrst_mem200");
    expect_state(1'b0, 3, 32'd0, "midrst_r3");
    run_until_halt(400, "midrst");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (state_of(e.is_mem, e.idx) !== e.value) begin
        failures++;
        $display("FAIL %s: got %0h required %0h", e.name, state_of(e.is_mem, e.idx), e.value);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_factorial();
    test_back_to_back();
    test_branch();
    test_load_mul();
    test_store_halt();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
